// File: rtl/mem_sram_pkg.sv
// Shared types and widths for the streamed memory request/response protocol.
package mem_sram_pkg;

  localparam int DataWidth = 32;
  localparam int StrbWidth = 4;
  localparam int AddrWidth = 32;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [StrbWidth-1:0] be;
    logic [DataWidth-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } mem_resp_t;

endpackage

// File: rtl/mem_sram_responder_if.sv
// Request/response bundle between a memory initiator (master) and a responder (slave).
interface mem_sram_responder_if;
  import mem_sram_pkg::*;

  mem_req_t  mem_req_i;
  logic      mem_req_valid_i;
  logic      mem_req_ready_o;
  mem_resp_t mem_resp_o;
  logic      mem_resp_valid_o;

  modport master (
    output mem_req_i, mem_req_valid_i,
    input  mem_req_ready_o, mem_resp_o, mem_resp_valid_o
  );

  modport slave (
    input  mem_req_i, mem_req_valid_i,
    output mem_req_ready_o, mem_resp_o, mem_resp_valid_o
  );
endinterface

// File: rtl/mem_resp_delay.sv
// Fixed-depth shift register of {valid, payload}; only the valid bits are cleared.
module mem_resp_delay
  import mem_sram_pkg::*;
#(
  parameter int  Depth = 1,
  parameter type T     = mem_resp_t
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  logic [Depth-1:0] valid_q;
  T                 data_q [Depth];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    data_q[0] <= data_i;
    for (int i = 1; i < Depth; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/mem_sram_responder.sv
// Scratchpad responder: byte-enable word storage, range check, fixed-latency
// in-order responses and optional periodic request throttling.
module mem_sram_responder
  import mem_sram_pkg::*;
#(
  parameter int NumWords    = 256,
  parameter int Latency     = 1,
  parameter int ReadyPeriod = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_sram_responder_if.slave  bus
);

  localparam int IdxWidth = $clog2(NumWords);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic                 rst_q;
  logic                 req_ready;
  logic                 accept;
  logic                 in_range;
  logic                 wr_en;
  logic [IdxWidth-1:0]  idx;
  mem_resp_t            resp_d;
  mem_resp_t            resp_q;
  logic                 resp_valid_q;
  logic                 unused_addr_lsb;

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
  end

  assign accept          = bus.mem_req_valid_i & req_ready;
  assign idx             = bus.mem_req_i.addr[2 +: IdxWidth];
  assign in_range        = ~|bus.mem_req_i.addr[AddrWidth-1:2+IdxWidth];
  assign wr_en           = accept & bus.mem_req_i.we & in_range;
  assign unused_addr_lsb = ^bus.mem_req_i.addr[1:0];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (bus.mem_req_i.be[b]) begin
          mem_q[idx][8*b +: 8] <= bus.mem_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured by the first delay stage, so this is a registered read.
  always_comb begin
    resp_d     = '0;
    resp_d.err = ~in_range;
    if (~bus.mem_req_i.we & in_range) begin
      resp_d.rdata = mem_q[idx];
    end
  end

  if (ReadyPeriod > 0) begin : g_thr
    localparam int ThrWidth = (ReadyPeriod > 1) ? $clog2(ReadyPeriod) : 1;
    localparam logic [ThrWidth-1:0] ThrLast = ThrWidth'(ReadyPeriod - 1);

    logic [ThrWidth-1:0] thr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        thr_q <= '0;
      end else if (thr_q == ThrLast) begin
        thr_q <= '0;
      end else begin
        thr_q <= thr_q + 1'b1;
      end
    end

    assign req_ready = ~rst_q & (thr_q != ThrLast);
  end else begin : g_no_thr
    assign req_ready = ~rst_q;
  end

  mem_resp_delay #(
    .Depth (Latency),
    .T     (mem_resp_t)
  ) u_delay (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .valid_i (accept),
    .data_i  (resp_d),
    .valid_o (resp_valid_q),
    .data_o  (resp_q)
  );

  assign bus.mem_req_ready_o  = req_ready;
  assign bus.mem_resp_valid_o = resp_valid_q;
  // Payload stages are not reset; gating keeps the idle/reset response at zero.
  assign bus.mem_resp_o       = resp_valid_q ? resp_q : '0;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Randomized and directed checks of mem_sram_responder against a word-array
// reference model with a timed expected-response queue.
module tb_mem_sram_responder;
  import mem_sram_pkg::*;

  localparam int LAT = 3;
  localparam int RP  = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          due;
  } exp_t;

  logic clk_i;
  logic rst_i;

  mem_sram_responder_if bus ();

  mem_sram_responder #(
    .NumWords    (256),
    .Latency     (LAT),
    .ReadyPeriod (RP)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rel     = 0;
  int          resp_cnt = 0;
  bit          chk_en  = 0;
  exp_t        exp_q [$];
  logic [31:0] model_mem [256];
  bit          known [256];
  mem_resp_t   last_resp;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // cyc numbers clock cycles; rel counts cycles since the last edge that saw reset.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    rel <= rst_i ? 0 : rel + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    bit   exp_v;
    if (chk_en) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("req_ready", 64'(bus.mem_req_ready_o), 64'((rel != 0) && (rel % RP != RP - 1)));
      check("resp_valid", 64'(bus.mem_resp_valid_o), 64'(exp_v));
      if (rel == 0) check("resp_in_reset", 64'(bus.mem_resp_o), 64'd0);
      if (exp_v) begin
        e = exp_q.pop_front();
        check("resp_err", 64'(bus.mem_resp_o.err), 64'(e.err));
        if (e.chk) check("resp_rdata", 64'(bus.mem_resp_o.rdata), 64'(e.rdata));
      end
      if (bus.mem_resp_valid_o === 1'b1) begin
        last_resp = bus.mem_resp_o;
        resp_cnt++;
      end
    end
  end

  // One attempt: present the request for one cycle and record it if accepted.
  task automatic try_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, output bit acc);
    exp_t e;
    int   idx;
    bus.mem_req_i       = '{addr: addr, we: we, be: be, wdata: wdata};
    bus.mem_req_valid_i = 1'b1;
    @(negedge clk_i);
    acc = (bus.mem_req_ready_o === 1'b1);
    if (acc) begin
      idx     = int'(addr[9:2]);
      e.err   = (addr >= 32'h400);
      e.rdata = '0;
      e.chk   = 1'b1;
      e.due   = cyc + LAT;
      if (!we && !e.err) begin
        e.rdata = model_mem[idx];
        e.chk   = known[idx];
      end
      exp_q.push_back(e);
      if (we && !e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (be == 4'hF) known[idx] = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    bus.mem_req_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata);
    bit acc = 0;
    int n   = 0;
    while (!acc && n < 20) begin
      try_req(addr, we, be, wdata, acc);
      n++;
    end
    if (!acc) check("req_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    idle(1);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    idle(1);
    exp_q.delete();
    if (n > 1) idle(n - 1);
    rst_i = 1'b0;
  endtask

  initial begin
    bit          acc;
    int          acc_cnt;
    int          cnt_snap;
    logic [31:0] a;

    rst_i               = 1'b1;
    bus.mem_req_i       = '0;
    bus.mem_req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    idle(2);
    rst_i = 1'b0;
    idle(4);

    // Full write then read back.
    do_req(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    do_req(32'h10, 1'b0, 4'h0, 32'h0);
    drain();
    check("wr_rd_rdata", 64'(last_resp.rdata), 64'hDEADBEEF);
    check("wr_rd_err", 64'(last_resp.err), 64'd0);

    // Partial byte-enable write.
    do_req(32'h10, 1'b1, 4'h5, 32'h11223344);
    do_req(32'h13, 1'b0, 4'h0, 32'h0);
    drain();
    check("be_rdata", 64'(last_resp.rdata), 64'hDE22BE44);

    // Out-of-range must not alias onto word 0.
    do_req(32'h0, 1'b1, 4'hF, 32'h01234567);
    do_req(32'h400, 1'b1, 4'hF, 32'hFFFFFFFF);
    drain();
    check("oor_wr_err", 64'(last_resp.err), 64'd1);
    do_req(32'h400, 1'b0, 4'h0, 32'h0);
    drain();
    check("oor_rd_err", 64'(last_resp.err), 64'd1);
    check("oor_rd_rdata", 64'(last_resp.rdata), 64'd0);
    do_req(32'h0, 1'b0, 4'h0, 32'h0);
    drain();
    check("oor_word0", 64'(last_resp.rdata), 64'h01234567);

    // be=0 write leaves storage untouched.
    do_req(32'h0, 1'b1, 4'h0, 32'hA5A5A5A5);
    do_req(32'h0, 1'b0, 4'h0, 32'h0);
    drain();
    check("be0_word0", 64'(last_resp.rdata), 64'h01234567);

    // Throughput: back-to-back reads of distinct words.
    for (int i = 0; i < 8; i++) do_req(32'h40 + 32'(i * 4), 1'b1, 4'hF, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 8; i++) do_req(32'h40 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
    drain();
    check("thru_last", 64'(last_resp.rdata), 64'hC0DE0007);

    // Randomized traffic over a small window plus occasional out-of-range.
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      do_req(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Throttle: valid held for 16 cycles starting one cycle after reset release.
    do_reset(2);
    idle(1);
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      try_req(32'h0, 1'b0, 4'h0, 32'h0, acc);
      if (acc) acc_cnt++;
    end
    drain();
    check("throttle_accepts", 64'(acc_cnt), 64'd12);

    // Reset mid-flight: pending reads vanish, storage survives.
    do_req(32'h20, 1'b1, 4'hF, 32'hCAFEF00D);
    drain();
    do_req(32'h20, 1'b0, 4'h0, 32'h0);
    do_req(32'h24, 1'b0, 4'h0, 32'h0);
    do_reset(1);
    cnt_snap = resp_cnt;
    idle(LAT + 4);
    check("flight_dropped", 64'(resp_cnt), 64'(cnt_snap));
    do_req(32'h20, 1'b0, 4'h0, 32'h0);
    drain();
    check("post_reset_rdata", 64'(last_resp.rdata), 64'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_sram_responder.md
# mem_sram_responder

Memory-side responder for the streamed memory request/response protocol. Accepts requests on a `valid`/`ready` request channel and returns exactly one response per accepted request on a response channel that has no backpressure, after a fixed latency. Sits behind a stream-to-memory adapter as the on-chip scratchpad and as the bench memory model. Backed by an internal register array with byte-enable writes. Request acceptance can be throttled to exercise the initiator's flow control.

## Interface
- `NumWords`, 256: words of storage; power of two, ≥ 2.
- `Latency`, 1: cycles from request accept to response valid; ≥ 1.
- `ReadyPeriod`, 0: `mem_req_ready_o` is low one cycle out of every `ReadyPeriod` cycles; 0 = never throttled; 1 is illegal.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `mem_req_i` in `mem_req_t`: request payload `{addr[31:0], we, be[3:0], wdata[31:0]}`; `addr` is a byte address.
- `mem_req_valid_i` in 1: request payload valid.
- `mem_req_ready_o` out 1: request can be accepted this cycle.
- `mem_resp_o` out `mem_resp_t`: response payload `{rdata[31:0], err}`.
- `mem_resp_valid_o` out 1: response valid; single-cycle pulse, no ready.

## Operation
- Accept occurs when `mem_req_valid_i & mem_req_ready_o`. Payload is sampled only at accept.
- Word index is `addr[2 +: log2(NumWords)]`. `addr[1:0]` is ignored.
- Out of range means `addr[31:2] >= NumWords`. Such a request returns `err=1` and `rdata=0`, and a write has no effect.
- Write (`we=1`, in range): for each `i` with `be[i]=1`, byte `i` of the word takes `wdata[8i +: 8]`. Other bytes are unchanged. Response is `rdata=0`, `err=0`.
- Read (`we=0`, in range): `rdata` is the word content at the accept edge. A write accepted in cycle t is visible to a read accepted in cycle t+1. Response has `err=0`.
- `be=0` on a write is legal: it produces a response and changes no storage.
- Throttle counter `thr_q`, width `$clog2(ReadyPeriod)`, present only when `ReadyPeriod > 0`:
  - counts 0 … `ReadyPeriod-1` every cycle and wraps to 0;
  - runs independently of `mem_req_valid_i`;
  - `mem_req_ready_o = !rst_q & (thr_q != ReadyPeriod-1)`.
- There is no outstanding-request limit. The response pipeline always has room, so back-to-back accepts give back-to-back responses.
- Responses are delivered strictly in accept order.

## Timing
- Reset values:
  - `mem_req_ready_o=0` while `rst_i=1` and for the first cycle after deassertion (registered `rst_q`);
  - `mem_resp_valid_o=0`, `mem_resp_o='0`, `thr_q=0`.
- Storage is not reset. Reads of never-written words return undefined data.
- Latency: a request accepted at edge t drives `mem_resp_valid_o=1` for exactly the cycle after edge t+`Latency`-1. With `Latency=1`, the response is visible in the cycle following the accept.
- Response timing is independent of throttling and of later requests.
- Reset mid-operation clears all pipeline valid bits. In-flight responses are dropped and never emitted. Storage keeps its contents.
- Simultaneous events: a read and a write to the same word cannot occur in one cycle, because there is one request channel.

## Structure
- Package `mem_sram_pkg` holds:
  - `mem_req_t` and `mem_resp_t` packed structs;
  - `DataWidth=32`, `StrbWidth=4`, `AddrWidth=32`.
- Sub-module `mem_resp_delay` (parameter `Depth=Latency`, type `T=mem_resp_t`): a shift register of `{valid, payload}` stages.
  - Synchronous active-high clear of the valid bits.
  - Payload registers are not reset.
- The top level contains the storage array, address decode/range check, byte-enable write, throttle counter and ready logic.

## Test plan
- Write then read, `Latency=1`, `ReadyPeriod=0`:
  - stimulus: write `addr=0x10`, `be=0xF`, `wdata=0xDEADBEEF` at cycle 5; read `addr=0x10` at cycle 6;
  - required response: a write response (`rdata=0`, `err=0`) in cycle 6, then `rdata=0xDEADBEEF` in cycle 7.
- Byte enable:
  - stimulus: after the above, write `be=0x5`, `wdata=0x11223344`, then read `0x10`;
  - required response: `rdata=0xDE22BE44`.
- Out of range, `NumWords=256`:
  - stimulus: write `addr=0x400`, then read `addr=0x400`;
  - required response: both responses have `err=1`, `rdata=0`; a read of `0x0` is unchanged.
- Throughput, `Latency=3`:
  - stimulus: 8 back-to-back reads with `valid` held high;
  - required response: 8 consecutive `resp_valid` cycles, the first 3 cycles after the first accept, in order.
- Throttle, `ReadyPeriod=4`:
  - stimulus: `valid` held high for 16 cycles;
  - required response: `ready` is low in cycles 3, 7, 11, 15 after reset release (plus cycle 0), giving 12 accepts and 12 responses.
- Reset mid-flight, `Latency=3`:
  - stimulus: accept 2 reads, then pulse `rst_i` for 1 cycle before their responses are due;
  - required response: no `resp_valid` ever appears for those reads; a write made before the reset is still readable afterwards.
